// File: rtl/msx_kbd_pkg.sv
// Shared definitions for the PS/2-to-MSX keyboard matrix bridge:
// receive FSM state encodings, PS/2 prefix codes, matrix geometry and
// a helper that packs a keymap entry.
package msx_kbd_pkg;

  localparam int unsigned MATRIX_ROWS = 11;

  // Receive FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 scan-code set 2 prefixes and special bytes
  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_PAUSE    = 8'hE1;
  localparam logic [7:0] PS2_ERR_ZERO = 8'h00;
  localparam logic [7:0] PS2_OVERFLOW = 8'hFF;

  // Bytes following E1 that belong to the Pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keymap entry: {valid, row[3:0], bit[2:0]}
  function automatic logic [7:0] km(input logic [3:0] r, input logic [2:0] b);
    return {1'b1, r, b};
  endfunction

endpackage

// File: rtl/msx_keymap.sv
// Combinational PS/2 set-2 to MSX international matrix lookup.
// Ports: ext (E0 prefix seen), code (scan code) -> valid, row, bit_pos.
module msx_keymap
  import msx_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       valid,
  output logic [3:0] row,
  output logic [2:0] bit_pos
);

  logic [7:0] ent_c;

  // Rows 0..10 of the MSX matrix; unlisted codes (incl. AA, FA) are unmapped
  always_comb begin
    ent_c = '0;
    case ({ext, code})
      9'h045: ent_c = km(4'd0, 3'd0);   9'h016: ent_c = km(4'd0, 3'd1);
      9'h01E: ent_c = km(4'd0, 3'd2);   9'h026: ent_c = km(4'd0, 3'd3);
      9'h025: ent_c = km(4'd0, 3'd4);   9'h02E: ent_c = km(4'd0, 3'd5);
      9'h036: ent_c = km(4'd0, 3'd6);   9'h03D: ent_c = km(4'd0, 3'd7);
      9'h03E: ent_c = km(4'd1, 3'd0);   9'h046: ent_c = km(4'd1, 3'd1);
      9'h04E: ent_c = km(4'd1, 3'd2);   9'h055: ent_c = km(4'd1, 3'd3);
      9'h05D: ent_c = km(4'd1, 3'd4);   9'h054: ent_c = km(4'd1, 3'd5);
      9'h05B: ent_c = km(4'd1, 3'd6);   9'h04C: ent_c = km(4'd1, 3'd7);
      9'h052: ent_c = km(4'd2, 3'd0);   9'h00E: ent_c = km(4'd2, 3'd1);
      9'h041: ent_c = km(4'd2, 3'd2);   9'h049: ent_c = km(4'd2, 3'd3);
      9'h04A: ent_c = km(4'd2, 3'd4);   9'h01C: ent_c = km(4'd2, 3'd6);
      9'h032: ent_c = km(4'd2, 3'd7);   9'h021: ent_c = km(4'd3, 3'd0);
      9'h023: ent_c = km(4'd3, 3'd1);   9'h024: ent_c = km(4'd3, 3'd2);
      9'h02B: ent_c = km(4'd3, 3'd3);   9'h034: ent_c = km(4'd3, 3'd4);
      9'h033: ent_c = km(4'd3, 3'd5);   9'h043: ent_c = km(4'd3, 3'd6);
      9'h03B: ent_c = km(4'd3, 3'd7);   9'h042: ent_c = km(4'd4, 3'd0);
      9'h04B: ent_c = km(4'd4, 3'd1);   9'h03A: ent_c = km(4'd4, 3'd2);
      9'h031: ent_c = km(4'd4, 3'd3);   9'h044: ent_c = km(4'd4, 3'd4);
      9'h04D: ent_c = km(4'd4, 3'd5);   9'h015: ent_c = km(4'd4, 3'd6);
      9'h02D: ent_c = km(4'd4, 3'd7);   9'h01B: ent_c = km(4'd5, 3'd0);
      9'h02C: ent_c = km(4'd5, 3'd1);   9'h03C: ent_c = km(4'd5, 3'd2);
      9'h02A: ent_c = km(4'd5, 3'd3);   9'h01D: ent_c = km(4'd5, 3'd4);
      9'h022: ent_c = km(4'd5, 3'd5);   9'h035: ent_c = km(4'd5, 3'd6);
      9'h01A: ent_c = km(4'd5, 3'd7);
      // Modifiers and F1..F3: LShift/RShift, L/R Ctrl, Alt=GRAPH, Caps, AltGr=CODE
      9'h012: ent_c = km(4'd6, 3'd0);   9'h059: ent_c = km(4'd6, 3'd0);
      9'h014: ent_c = km(4'd6, 3'd1);   9'h114: ent_c = km(4'd6, 3'd1);
      9'h011: ent_c = km(4'd6, 3'd2);   9'h058: ent_c = km(4'd6, 3'd3);
      9'h111: ent_c = km(4'd6, 3'd4);   9'h005: ent_c = km(4'd6, 3'd5);
      9'h006: ent_c = km(4'd6, 3'd6);   9'h004: ent_c = km(4'd6, 3'd7);
      // F4, F5, Esc, Tab, F8=STOP, Backspace, F7=SELECT, Enter
      9'h00C: ent_c = km(4'd7, 3'd0);   9'h003: ent_c = km(4'd7, 3'd1);
      9'h076: ent_c = km(4'd7, 3'd2);   9'h00D: ent_c = km(4'd7, 3'd3);
      9'h00A: ent_c = km(4'd7, 3'd4);   9'h066: ent_c = km(4'd7, 3'd5);
      9'h083: ent_c = km(4'd7, 3'd6);   9'h05A: ent_c = km(4'd7, 3'd7);
      9'h15A: ent_c = km(4'd7, 3'd7);
      // Space and the extended navigation cluster
      9'h029: ent_c = km(4'd8, 3'd0);   9'h16C: ent_c = km(4'd8, 3'd1);
      9'h170: ent_c = km(4'd8, 3'd2);   9'h171: ent_c = km(4'd8, 3'd3);
      9'h16B: ent_c = km(4'd8, 3'd4);   9'h175: ent_c = km(4'd8, 3'd5);
      9'h172: ent_c = km(4'd8, 3'd6);   9'h174: ent_c = km(4'd8, 3'd7);
      // Numeric keypad
      9'h07C: ent_c = km(4'd9, 3'd0);   9'h079: ent_c = km(4'd9, 3'd1);
      9'h14A: ent_c = km(4'd9, 3'd2);   9'h070: ent_c = km(4'd9, 3'd3);
      9'h069: ent_c = km(4'd9, 3'd4);   9'h072: ent_c = km(4'd9, 3'd5);
      9'h07A: ent_c = km(4'd9, 3'd6);   9'h06B: ent_c = km(4'd9, 3'd7);
      9'h073: ent_c = km(4'd10, 3'd0);  9'h074: ent_c = km(4'd10, 3'd1);
      9'h06C: ent_c = km(4'd10, 3'd2);  9'h075: ent_c = km(4'd10, 3'd3);
      9'h07D: ent_c = km(4'd10, 3'd4);  9'h07B: ent_c = km(4'd10, 3'd5);
      9'h071: ent_c = km(4'd10, 3'd7);
      default: ent_c = '0;
    endcase
  end

  assign {valid, row, bit_pos} = ent_c;

endmodule

// File: rtl/msx_keyboard.sv
// PS/2 keyboard receiver feeding an emulated MSX 11x8 key matrix.
// Ports: clk, reset_n (sync, active-low), ps2_clk/ps2_data (async PS/2 lines),
// row (PPI C[3:0] select) -> cols (active-low, 1-clk latency),
// key_strobe (accepted non-prefix code), frame_err (rejected frame).
module msx_keyboard
  import msx_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] row,
  output logic [7:0] cols,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW = 4;

  logic          clk_meta, clk_sync, dat_meta, dat_sync;
  logic          filt_clk, fall_q, bit_q;
  logic [FW-1:0] flt_cnt;
  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          parity_q;
  logic [TW-1:0] to_cnt_q;
  logic          rx_ok_c, rx_err_c, to_exp_c;
  logic          brk_q, ext_q;
  logic [2:0]    skip_q;
  logic [MATRIX_ROWS-1:0][7:0] matrix;
  logic          map_valid;
  logic [3:0]    map_row;
  logic [2:0]    map_bit;

  // Synchronizers and ps2_clk glitch filter; fall_q/bit_q mark a filtered falling edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      dat_meta <= ps2_data;
      dat_sync <= dat_meta;
      fall_q   <= 1'b0;
      if (clk_sync == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        flt_cnt  <= '0;
        fall_q   <= filt_clk;
        if (filt_clk) bit_q <= dat_sync;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Receive FSM next state and frame verdict
  always_comb begin
    state_d  = state_q;
    rx_ok_c  = 1'b0;
    rx_err_c = 1'b0;
    to_exp_c = (state_q != ST_IDLE) && !fall_q && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    if (to_exp_c) begin
      state_d = ST_IDLE;
    end else if (fall_q) begin
      case (state_q)
        ST_IDLE:   if (!bit_q) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_q && (^{parity_q, shift_q})) rx_ok_c  = 1'b1;
          else                                 rx_err_c = 1'b1;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: LSB-first shifter, bit counter, parity, idle timeout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE || fall_q) to_cnt_q <= '0;
      else                              to_cnt_q <= to_cnt_q + TW'(1);
      if (fall_q) begin
        case (state_q)
          ST_IDLE:   bit_cnt_q <= '0;
          ST_DATA: begin
            shift_q   <= {bit_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          ST_PARITY: parity_q <= bit_q;
          default: ;
        endcase
      end
    end
  end

  msx_keymap u_keymap (
    .ext     (ext_q),
    .code    (shift_q),
    .valid   (map_valid),
    .row     (map_row),
    .bit_pos (map_bit)
  );

  // Scan-code interpretation and matrix update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      skip_q     <= '0;
      matrix     <= '0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= rx_err_c;
      if (rx_ok_c) begin
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 3'd1;
        end else if (shift_q == PS2_BREAK) begin
          brk_q <= 1'b1;
        end else if (shift_q == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_PAUSE) begin
          skip_q <= PAUSE_SKIP;
        end else begin
          key_strobe <= 1'b1;
          brk_q      <= 1'b0;
          ext_q      <= 1'b0;
          if (shift_q == PS2_ERR_ZERO || shift_q == PS2_OVERFLOW) matrix <= '0;
          else if (map_valid) matrix[map_row][map_bit] <= ~brk_q;
        end
      end
    end
  end

  // Column read-back; sees the matrix before any same-cycle update
  always_ff @(posedge clk) begin
    if (!reset_n)                    cols <= 8'hFF;
    else if (row < RW'(MATRIX_ROWS)) cols <= ~matrix[row];
    else                             cols <= 8'hFF;
  end

endmodule

// File: tb/tb_msx_keyboard.sv
// Directed bench for msx_keyboard: bit-bangs PS/2 frames and reads matrix rows.
module tb_msx_keyboard;

  localparam int HALF = 20;

  logic       clk;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] row;
  logic [7:0] cols;
  logic       key_strobe;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int ks_cnt = 0;
  int fe_cnt = 0;
  int ks0, fe0;

  msx_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYC(200)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .row        (row),
    .cols       (cols),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (key_strobe) ks_cnt = ks_cnt + 1;
    if (frame_err)  fe_cnt = fe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_row(input logic [3:0] r, input logic [7:0] exp, input string tag);
    row = r;
    tick(1);
    check(tag, cols, exp);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic good);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(good ? ~^d : ^d);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(10);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    row      = 4'd0;
    tick(3);
    check("rst_cols", cols, 8'hFF);
    check("rst_strobe", {7'd0, key_strobe}, 8'd0);
    check("rst_ferr", {7'd0, frame_err}, 8'd0);
    reset_n = 1'b1;
    tick(5);
    read_row(4'd15, 8'hFF, "row15_idle");

    // Make A
    ks0 = ks_cnt;
    send(8'h1C, 1'b1);
    check("a_strobe", 8'(ks_cnt - ks0), 8'd1);
    read_row(4'd0, 8'hFF, "row0_after_a");
    read_row(4'd2, 8'hBF, "a_make");

    // Break A
    ks0 = ks_cnt;
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    check("a_brk_strobe", 8'(ks_cnt - ks0), 8'd1);
    read_row(4'd2, 8'hFF, "a_break");

    // Plain 75 is keypad 8, extended 75 is Up
    send(8'h75, 1'b1);
    read_row(4'd8, 8'hFF, "kp8_not_up");
    read_row(4'd10, 8'hF7, "kp8_make");
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    read_row(4'd8, 8'hDF, "up_make");
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    read_row(4'd8, 8'hFF, "up_break");
    read_row(4'd10, 8'hFF, "kp8_break");

    // Unmapped code still strobes
    ks0 = ks_cnt;
    send(8'hAA, 1'b1);
    check("aa_strobe", 8'(ks_cnt - ks0), 8'd1);
    read_row(4'd2, 8'hFF, "aa_no_effect");

    // Bad parity on Space
    ks0 = ks_cnt;
    fe0 = fe_cnt;
    send(8'h29, 1'b0);
    check("par_ferr", 8'(fe_cnt - fe0), 8'd1);
    check("par_strobe", 8'(ks_cnt - ks0), 8'd0);
    read_row(4'd8, 8'hFF, "par_space");

    // Partial frame then idle timeout, then Enter
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(300);
    send(8'h5A, 1'b1);
    check("to_ferr", 8'(fe_cnt - fe0), 8'd0);
    read_row(4'd7, 8'h7F, "to_enter");

    // Glitch immunity, then overflow clears everything
    send(8'h1C, 1'b1);
    send(8'h12, 1'b1);
    read_row(4'd2, 8'hBF, "gl_a");
    read_row(4'd6, 8'hFE, "gl_shift");
    ks0 = ks_cnt;
    fe0 = fe_cnt;
    repeat (4) begin
      ps2_clk = 1'b0;
      tick(1);
      ps2_clk = 1'b1;
      tick(30);
    end
    ps2_clk = 1'b0;
    tick(7);
    ps2_clk = 1'b1;
    tick(30);
    check("gl_strobe", 8'(ks_cnt - ks0), 8'd0);
    check("gl_ferr", 8'(fe_cnt - fe0), 8'd0);
    read_row(4'd2, 8'hBF, "gl_a_hold");
    read_row(4'd12, 8'hFF, "row12");
    send(8'hFF, 1'b1);
    read_row(4'd2, 8'hFF, "ovf_row2");
    read_row(4'd6, 8'hFF, "ovf_row6");
    read_row(4'd7, 8'hFF, "ovf_row7");

    // Pause sequence: E1 plus seven swallowed bytes
    ks0 = ks_cnt;
    send(8'hE1, 1'b1);
    send(8'h14, 1'b1);
    send(8'h77, 1'b1);
    send(8'hE1, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h14, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h77, 1'b1);
    check("pause_strobe", 8'(ks_cnt - ks0), 8'd0);
    read_row(4'd6, 8'hFF, "pause_ctrl");
    send(8'h1C, 1'b1);
    check("post_pause_strobe", 8'(ks_cnt - ks0), 8'd1);
    read_row(4'd2, 8'hBF, "post_pause_a");

    // Reset in the middle of a frame
    ks0 = ks_cnt;
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    reset_n  = 1'b0;
    tick(2);
    check("mid_rst_cols", cols, 8'hFF);
    reset_n = 1'b1;
    tick(300);
    check("mid_rst_strobe", 8'(ks_cnt - ks0), 8'd0);
    check("mid_rst_ferr", 8'(fe_cnt - fe0), 8'd0);
    read_row(4'd2, 8'hFF, "mid_rst_matrix");
    send(8'h29, 1'b1);
    read_row(4'd8, 8'hFE, "space_make");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
